// File: rtl/rr_arbiter32.sv
// Round-robin arbiter for 32 requesters sharing the mux32 data path.
// Registered one-hot grant and mux select, with optional hold-time revocation.
module rr_arbiter32 #(
    parameter int unsigned N        = 32,
    parameter int unsigned IDXW     = 5,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNTW     = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            release_i,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] sel,
    output logic            busy,
    output logic            timeout
);

    typedef enum logic [0:0] {IDLE, GRANT} state_t;

    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [CNTW-1:0] CNT_MAX   = '1;
    localparam logic [IDXW:0]   N_EXT     = (IDXW + 1)'(N);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(N - 1);

    state_t            state_q, state_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [IDXW-1:0]   sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    logic [2*N-1:0]    req_dbl;
    logic [N-1:0]      req_rot;
    logic [IDXW-1:0]   win_off;
    logic [IDXW:0]     win_sum;
    logic [IDXW-1:0]   win_idx;
    logic              rel_a, rel_b, rel_c;

    // Rotate req so ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req_dbl = {req, req} >> ptr_q;
        req_rot = req_dbl[N-1:0];
        win_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) win_off = IDXW'(k);
        end
        win_sum = {1'b0, ptr_q} + {1'b0, win_off};
        if (win_sum >= N_EXT) win_sum = win_sum - N_EXT;
        win_idx = win_sum[IDXW-1:0];
    end

    always_comb begin
        rel_a = release_i;
        rel_b = !req[sel_q];
        rel_c = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    gnt_d   = N'(1) << win_idx;
                    sel_d   = win_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (rel_a || rel_b || rel_c) begin
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                    ptr_d     = (sel_q == LAST_IDX) ? '0 : sel_q + IDXW'(1);
                    timeout_d = rel_c && !rel_a && !rel_b;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter32.sv
// Directed bench for rr_arbiter32: grant order, bubbles, hold timeout and reset.
module tb_rr_arbiter32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] req = '0;
    logic        release_i = 1'b0;
    logic [31:0] gnt;
    logic [4:0]  sel;
    logic        busy;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    logic [4:0] mux_d [32];
    logic [4:0] mux_y;

    rr_arbiter32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .release_i (release_i),
        .gnt       (gnt),
        .sel       (sel),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // mux32 stand-in with d_i = i
    initial for (int i = 0; i < 32; i++) mux_d[i] = 5'(i);
    assign mux_y = mux_d[sel];

    always @(negedge clk) begin
        if (busy) begin
            checks++;
            if (mux_y !== sel) begin
                errors++;
                $display("FAIL mux_y: got %0d expected %0d", mux_y, sel);
            end
            checks++;
            if (gnt !== (32'd1 << sel)) begin
                errors++;
                $display("FAIL gnt_onehot: got %h expected %h", gnt, 32'd1 << sel);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; release_i = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 32'hFFFF_FFFF;
        step();
        checks++; if (gnt !== 32'd0) begin errors++; $display("FAIL rst_gnt: got %h expected 0", gnt); end
        checks++; if (sel !== 5'd0) begin errors++; $display("FAIL rst_sel: got %0d expected 0", sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b expected 0", timeout); end
        rst_n = 1'b1; req = 32'd1 << 7;
        step();
        checks++; if (gnt !== (32'd1 << 7)) begin errors++; $display("FAIL single_gnt: got %h expected %h", gnt, 32'd1 << 7); end
        checks++; if (sel !== 5'd7) begin errors++; $display("FAIL single_sel: got %0d expected 7", sel); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        release_i = 1'b1; req = '0;
        step();
        release_i = 1'b0;
        checks++; if (gnt !== 32'd0) begin errors++; $display("FAIL single_rel_gnt: got %h expected 0", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_rel_busy: got %b expected 0", busy); end
        checks++; if (sel !== 5'd7) begin errors++; $display("FAIL single_rel_sel: got %0d expected 7", sel); end
        step();
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_seq [6];
        exp_seq = '{5'd3, 5'd17, 5'd31, 5'd3, 5'd17, 5'd31};
        do_reset();
        req = (32'd1 << 3) | (32'd1 << 17) | (32'd1 << 31);
        for (int g = 0; g < 6; g++) begin
            step();
            checks++; if (sel !== exp_seq[g]) begin errors++; $display("FAIL rr_sel[%0d]: got %0d expected %0d", g, sel, exp_seq[g]); end
            checks++; if (gnt !== (32'd1 << exp_seq[g])) begin errors++; $display("FAIL rr_gnt[%0d]: got %h expected %h", g, gnt, 32'd1 << exp_seq[g]); end
            step();
            release_i = 1'b1;
            step();
            release_i = 1'b0;
            checks++; if (gnt !== 32'd0) begin errors++; $display("FAIL rr_bubble[%0d]: got %h expected 0", g, gnt); end
            checks++; if (sel !== exp_seq[g]) begin errors++; $display("FAIL rr_bubble_sel[%0d]: got %0d expected %0d", g, sel, exp_seq[g]); end
        end
        req = 32'd1;
        step();
        checks++; if (sel !== 5'd0) begin errors++; $display("FAIL rr_wrap_sel: got %0d expected 0", sel); end
        checks++; if (gnt !== 32'd1) begin errors++; $display("FAIL rr_wrap_gnt: got %h expected 1", gnt); end
        req = '0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_wrap_drop: got %b expected 0", busy); end
    endtask

    task automatic test_timeout();
        int held;
        do_reset();
        req = 32'd1 << 5;
        held = 0;
        step();
        for (int i = 0; i < 20 && gnt == (32'd1 << 5); i++) begin
            held++;
            checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_early_pulse: got %b expected 0", timeout); end
            step();
        end
        checks++; if (held !== 16) begin errors++; $display("FAIL to_hold_len: got %0d expected 16", held); end
        checks++; if (gnt !== 32'd0) begin errors++; $display("FAIL to_revoke_gnt: got %h expected 0", gnt); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", timeout); end
        checks++; if (sel !== 5'd5) begin errors++; $display("FAIL to_sel_hold: got %0d expected 5", sel); end
        step();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_len: got %b expected 0", timeout); end
        checks++; if (gnt !== (32'd1 << 5)) begin errors++; $display("FAIL to_regrant: got %h expected %h", gnt, 32'd1 << 5); end
        release_i = 1'b1; req = '0;
        step();
        release_i = 1'b0;
    endtask

    task automatic test_owner_drop();
        do_reset();
        req = 32'd1 << 9;
        step();
        checks++; if (sel !== 5'd9) begin errors++; $display("FAIL drop_sel: got %0d expected 9", sel); end
        req = (32'd1 << 9) | (32'd1 << 2);
        step();
        step();
        step();
        checks++; if (gnt !== (32'd1 << 9)) begin errors++; $display("FAIL drop_nonowner_ignored: got %h expected %h", gnt, 32'd1 << 9); end
        req = 32'd1 << 2;
        step();
        checks++; if (gnt !== 32'd0) begin errors++; $display("FAIL drop_gnt: got %h expected 0", gnt); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL drop_timeout: got %b expected 0", timeout); end
        step();
        checks++; if (sel !== 5'd2) begin errors++; $display("FAIL drop_next_sel: got %0d expected 2", sel); end
        release_i = 1'b1; req = '0;
        step();
        release_i = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        req = 32'd1 << 5;
        step();
        for (int i = 0; i < 15; i++) step();
        checks++; if (gnt !== (32'd1 << 5)) begin errors++; $display("FAIL sim_last_cycle: got %h expected %h", gnt, 32'd1 << 5); end
        release_i = 1'b1;
        step();
        release_i = 1'b0; req = '0;
        checks++; if (gnt !== 32'd0) begin errors++; $display("FAIL sim_gnt: got %h expected 0", gnt); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL sim_timeout: got %b expected 0", timeout); end
        release_i = 1'b1;
        step();
        release_i = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_rel_busy: got %b expected 0", busy); end
        checks++; if (sel !== 5'd5) begin errors++; $display("FAIL idle_rel_sel: got %0d expected 5", sel); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL idle_rel_timeout: got %b expected 0", timeout); end
        req = (32'd1 << 4) | (32'd1 << 6);
        step();
        checks++; if (sel !== 5'd6) begin errors++; $display("FAIL idle_rel_ptr: got %0d expected 6", sel); end
        release_i = 1'b1; req = '0;
        step();
        release_i = 1'b0;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 32'd1 << 19;
        step();
        release_i = 1'b1; req = 32'd1 << 20;
        step();
        release_i = 1'b0;
        step();
        checks++; if (sel !== 5'd20) begin errors++; $display("FAIL mid_pre_sel: got %0d expected 20", sel); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 32'd0) begin errors++; $display("FAIL mid_async_gnt: got %h expected 0", gnt); end
        checks++; if (sel !== 5'd0) begin errors++; $display("FAIL mid_async_sel: got %0d expected 0", sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_async_busy: got %b expected 0", busy); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL mid_async_timeout: got %b expected 0", timeout); end
        req = (32'd1 << 20) | (32'd1 << 21);
        rst_n = 1'b1;
        step();
        checks++; if (sel !== 5'd20) begin errors++; $display("FAIL mid_after_sel: got %0d expected 20", sel); end
        release_i = 1'b1; req = '0;
        step();
        release_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_timeout();
        test_owner_drop();
        test_simultaneous();
        test_reset_mid_grant();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
